axis_accumulator: RTL
=====================

AXIS_ACCUMULATOR -- requirements
Module: axis_accumulator

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter PAR_WDATA_BYTE SHALL default to 2 and set the input data width DW = 8*PAR_WDATA_BYTE bits (legal range 1..2).
REQ-003 Parameter PAR_ACC_LEN SHALL default to 4 and set the number of beats per accumulation block (legal range 2..256).
REQ-004 Derived widths SHALL be AW = DW + clog2(PAR_ACC_LEN) and CW = clog2(PAR_ACC_LEN+1).
REQ-005 Port aclk SHALL be an input, 1 bit wide, and is the single clock.
REQ-006 Port aresetn SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-007 Port s_axis_tdata SHALL be an input, DW bits wide, carrying unsigned sum beats from the upstream adder.
REQ-008 Port s_axis_tvalid SHALL be an input, 1 bit wide, and is the input beat valid.
REQ-009 Port s_axis_tlast SHALL be an input, 1 bit wide, and requests early termination of the current block.
REQ-010 Port s_axis_tready SHALL be an output, 1 bit wide, and is the input beat ready.
REQ-011 Port m_axis_tdata SHALL be an output, AW bits wide, carrying the accumulated block sum.
REQ-012 Port m_axis_tuser SHALL be an output, CW bits wide, carrying the number of beats in the block.
REQ-013 Port m_axis_tvalid SHALL be an output, 1 bit wide, and is the result valid.
REQ-014 Port m_axis_tready SHALL be an input, 1 bit wide, and is the result ready.

Function
REQ-015 An input beat SHALL be accepted only when s_axis_tvalid && s_axis_tready is high on an aclk rising edge; an output beat completes only when m_axis_tvalid && m_axis_tready is high.
REQ-016 The FSM SHALL have exactly two states: ACCUM (collecting beats) and HOLD (result presented).
REQ-017 In ACCUM, s_axis_tready SHALL be 1 and m_axis_tvalid SHALL be 0.
REQ-018 In HOLD, m_axis_tvalid SHALL be 1 and s_axis_tready SHALL equal m_axis_tready (combinational pass-through), giving zero-bubble block handoff.
REQ-019 The first accepted beat of a block SHALL load acc = zero-extended tdata with count = 1; each later beat SHALL set acc = acc + tdata and count = count + 1.
REQ-020 Arithmetic SHALL be unsigned at AW bits; by width construction the sum never overflows.
REQ-021 ACCUM SHALL go to HOLD on the accepted beat where count reaches PAR_ACC_LEN, or on any accepted beat with s_axis_tlast = 1 (including the first beat of a block).
REQ-022 m_axis_tdata and m_axis_tuser SHALL be registered, equal acc and count including the terminating beat, and be visible in the cycle after that beat is accepted (latency 1 cycle).
REQ-023 In HOLD, m_axis_tdata and m_axis_tuser SHALL stay stable while m_axis_tready = 0.
REQ-024 When HOLD completes with no simultaneous input beat, the FSM SHALL return to ACCUM with count = 0.
REQ-025 When HOLD completes and an input beat is accepted in the same cycle, that beat SHALL start the next block (count = 1). The next state is ACCUM, or HOLD if that beat has tlast = 1.
REQ-026 s_axis_tlast on a beat that also reaches PAR_ACC_LEN SHALL produce a single result; no empty block is emitted.
REQ-027 The block SHALL never emit a result with count = 0.

Reset
REQ-028 When aresetn is low, the block SHALL immediately force state = ACCUM, acc = 0, count = 0, m_axis_tvalid = 0, m_axis_tdata = 0 and m_axis_tuser = 0.
REQ-029 A partial block or pending result present at reset assertion SHALL be discarded.
REQ-030 After aresetn deasserts, the first beat SHALL be accepted on the first aclk edge where s_axis_tvalid is high.

Structure
REQ-031 A shared package axis_pkg SHALL hold the state enum typedef (ACCUM, HOLD) and constant functions computing AW and CW.
REQ-032 The block SHALL be a single module with no sub-module instances and no inferred memories.

Verification (PAR_WDATA_BYTE = 2, PAR_ACC_LEN = 4)
REQ-033 Full block: four beats of 0xFFFF, tlast = 0 -> one result with tdata 0x3FFFC and tuser 4, one cycle after the fourth beat.
REQ-034 Early tlast: beats 0x0001, then 0x0002 with tlast = 1 -> result tdata 0x00003, tuser 2; no further output.
REQ-035 Backpressure: hold m_axis_tready = 0 for 5 cycles in HOLD -> tvalid stays 1, tdata/tuser are stable, s_axis_tready is 0, and no input is accepted.
REQ-036 Streaming: tready = 1 constantly, beats 1..8 back-to-back -> results 10/tuser 4 and 26/tuser 4, with s_axis_tready never low.
REQ-037 Handoff tlast: beat 0x0005 with tlast = 1 accepted in the HOLD-completion cycle -> the next result is tdata 5, tuser 1, on the following cycle.
REQ-038 Reset mid-block: pulse aresetn low after two beats -> tvalid goes 0 at once; the next four beats of 1 give tdata 4, tuser 4.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream accumulator: FSM state type and
// constant functions that derive the accumulator and beat-count widths.
package axis_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Width of the block sum: input width plus enough headroom for acc_len beats.
  function automatic int calc_aw(input int wdata_byte, input int acc_len);
    return 8 * wdata_byte + $clog2(acc_len);
  endfunction

  // Width of the beat counter: must represent acc_len itself.
  function automatic int calc_cw(input int acc_len);
    return $clog2(acc_len + 1);
  endfunction

endpackage

// File: rtl/axis_accumulator.sv
// Sums blocks of PAR_ACC_LEN unsigned beats (or fewer when tlast ends a block
// early) and presents each sum with its beat count as one output beat.
// While a result is held, input ready follows output ready so the next block
// can start in the same cycle the result is taken.
module axis_accumulator
  import axis_pkg::*;
#(
  parameter int PAR_WDATA_BYTE = 2,
  parameter int PAR_ACC_LEN    = 4,
  localparam int DW = 8 * PAR_WDATA_BYTE,
  localparam int AW = calc_aw(PAR_WDATA_BYTE, PAR_ACC_LEN),
  localparam int CW = calc_cw(PAR_ACC_LEN)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  output logic [AW-1:0] m_axis_tdata,
  output logic [CW-1:0] m_axis_tuser,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready
);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic in_fire;
  logic out_fire;
  logic first_beat;

  // Handshake decode; in HOLD the input side only moves when the result does.
  always_comb begin
    s_axis_tready = (state_q == ACCUM) ? 1'b1 : m_axis_tready;
    m_axis_tvalid = (state_q == HOLD);
    in_fire       = s_axis_tvalid && s_axis_tready;
    out_fire      = m_axis_tvalid && m_axis_tready;
    // A beat opens a new block after reset/completion (count 0) or when it
    // arrives in the same cycle the held result is taken.
    first_beat    = (state_q == HOLD) || (cnt_q == '0);
  end

  // Next-state, accumulator and counter update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    if (out_fire) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
    end

    if (in_fire) begin
      if (first_beat) begin
        acc_d = AW'(s_axis_tdata);
        cnt_d = CW'(1);
      end else begin
        acc_d = acc_q + AW'(s_axis_tdata);
        cnt_d = cnt_q + CW'(1);
      end
      // tlast on the beat that also fills the block still yields one result.
      state_d = (s_axis_tlast || (cnt_d == CW'(PAR_ACC_LEN))) ? HOLD : ACCUM;
    end
  end

  // State and result registers; reset discards any partial or pending block.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The accumulator and counter are the registered result; they are frozen
  // in HOLD until the output handshake completes.
  assign m_axis_tdata = acc_q;
  assign m_axis_tuser = cnt_q;

endmodule
